// File: rtl/bot_status_rx.sv
// Rojobot status snapshot receiver: queues {LocX,LocY,BotInfo,Sensors} on every upd_sysregs toggle
// and returns the motor control register. Optional watchdog enabled by BOT_STATUS_RX_WATCHDOG_EN.
module bot_status_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int WD_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_sysregs,
  input  logic [7:0]  LocX,
  input  logic [7:0]  LocY,
  input  logic [7:0]  BotInfo,
  input  logic [7:0]  Sensors,
  output logic [31:0] snap_data,
  output logic        snap_valid,
  input  logic        snap_ready,
  input  logic [7:0]  mot_cmd,
  input  logic        mot_cmd_wr,
  output logic [7:0]  MotCtl,
  output logic [7:0]  drop_cnt,
  output logic        wd_trip
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic          upd_q, upd_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          snap_valid_q, snap_valid_d;
  logic [31:0]   snap_data_q, snap_data_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [7:0]    cmd_reg_q, cmd_reg_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic          upd_event, pop, push, full, drop;
  logic [CW-1:0] survivors;
  logic [31:0]   wr_data, head;

  assign upd_event = upd_sysregs ^ upd_q;
  assign wr_data   = {LocX, LocY, BotInfo, Sensors};

  // The count disambiguates full from empty when the pointers coincide.
  always_comb begin
    upd_d     = upd_sysregs;
    pop       = snap_valid_q & snap_ready;
    full      = (count_q == CW'(FIFO_DEPTH));
    push      = upd_event & (~full | pop);
    drop      = upd_event & full & ~pop;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    survivors = count_q - CW'(pop);
    // An entry pushed into an empty queue becomes visible one cycle later.
    snap_valid_d = (count_q != '0) && (count_d != '0);
    head         = (push && survivors == '0) ? wr_data : mem_q[rd_ptr_d];
    snap_data_d  = snap_valid_d ? head : snap_data_q;
    drop_cnt_d   = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    cmd_reg_d    = mot_cmd_wr ? mot_cmd : cmd_reg_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
      drop_cnt_q   <= '0;
      cmd_reg_q    <= '0;
    end else begin
      upd_q        <= upd_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
      drop_cnt_q   <= drop_cnt_d;
      cmd_reg_q    <= cmd_reg_d;
    end
  end

  // NOTE: storage is not reset; the reset count and pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;
  assign drop_cnt   = drop_cnt_q;

`ifdef BOT_STATUS_RX_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYCLES);

  typedef enum logic {WD_RUN, WD_TRIP} wd_state_e;

  wd_state_e      wd_state_q, wd_state_d;
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_state_q <= WD_RUN;
      wd_cnt_q   <= '0;
    end else begin
      wd_state_q <= wd_state_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

  // Counter is frozen while tripped; any status update restarts it.
  always_comb begin
    wd_state_d = wd_state_q;
    wd_cnt_d   = wd_cnt_q;
    case (wd_state_q)
      WD_RUN: begin
        if (upd_event)                               wd_cnt_d   = '0;
        else if (wd_cnt_q == WDW'(WD_CYCLES - 1))    wd_state_d = WD_TRIP;
        else                                         wd_cnt_d   = wd_cnt_q + WDW'(1);
      end
      WD_TRIP: begin
        if (upd_event) begin
          wd_state_d = WD_RUN;
          wd_cnt_d   = '0;
        end
      end
      default: wd_state_d = WD_RUN;
    endcase
  end

  always_comb begin
    wd_trip = (wd_state_q == WD_TRIP);
    MotCtl  = wd_trip ? 8'h00 : cmd_reg_q;
  end
`else
  assign wd_trip = 1'b0;
  assign MotCtl  = cmd_reg_q;
`endif

endmodule

// File: tb/tb_bot_status_rx.sv
// Directed self-checking bench for bot_status_rx (FIFO_DEPTH=4, WD_CYCLES=16); checks adapt to
// whether BOT_STATUS_RX_WATCHDOG_EN is defined.
module tb_bot_status_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_sysregs;
  logic [7:0]  LocX, LocY, BotInfo, Sensors;
  logic [31:0] snap_data;
  logic        snap_valid;
  logic        snap_ready;
  logic [7:0]  mot_cmd;
  logic        mot_cmd_wr;
  logic [7:0]  MotCtl;
  logic [7:0]  drop_cnt;
  logic        wd_trip;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bot_status_rx #(.FIFO_DEPTH(4), .WD_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .upd_sysregs(upd_sysregs),
    .LocX(LocX), .LocY(LocY), .BotInfo(BotInfo), .Sensors(Sensors),
    .snap_data(snap_data), .snap_valid(snap_valid), .snap_ready(snap_ready),
    .mot_cmd(mot_cmd), .mot_cmd_wr(mot_cmd_wr), .MotCtl(MotCtl),
    .drop_cnt(drop_cnt), .wd_trip(wd_trip)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    upd_sysregs = 1'b0;
    snap_ready  = 1'b0;
    mot_cmd_wr  = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic toggle(input logic [31:0] w);
    {LocX, LocY, BotInfo, Sensors} = w;
    upd_sysregs = ~upd_sysregs;
    tick(1);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] locx);
    check({tag, "_valid"}, 32'(snap_valid), 32'd1);
    check({tag, "_locx"}, 32'(snap_data[31:24]), 32'(locx));
    snap_ready = 1'b1;
    tick(1);
    snap_ready = 1'b0;
  endtask

  task automatic write_cmd(input logic [7:0] c);
    mot_cmd    = c;
    mot_cmd_wr = 1'b1;
    tick(1);
    mot_cmd_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; upd_sysregs = 1'b0; snap_ready = 1'b0;
    {LocX, LocY, BotInfo, Sensors} = 32'h0;
    mot_cmd = 8'h00; mot_cmd_wr = 1'b0;
    tick(2);
    check("rst_valid", 32'(snap_valid), 32'd0);
    check("rst_data", snap_data, 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_motctl", 32'(MotCtl), 32'd0);
    check("rst_trip", 32'(wd_trip), 32'd0);
    reset = 1'b0;

    // Single snapshot: two-cycle latency, then held while not accepted.
    do_reset();
    toggle(32'h12345678);
    check("lat_valid_early", 32'(snap_valid), 32'd0);
    tick(1);
    check("lat_valid", 32'(snap_valid), 32'd1);
    check("lat_data", snap_data, 32'h12345678);
    tick(3);
    check("hold_valid", 32'(snap_valid), 32'd1);
    check("hold_data", snap_data, 32'h12345678);

    // Overflow: fifth snapshot dropped, first four drain in order.
    do_reset();
    for (int i = 1; i <= 5; i++) toggle({8'(i), 8'hA0, 8'hB0, 8'(i)});
    tick(1);
    check("ovf_drop", 32'(drop_cnt), 32'd1);
    for (int i = 1; i <= 4; i++) pop_expect("ovf_drain", 8'(i));
    check("ovf_empty", 32'(snap_valid), 32'd0);

    // Full FIFO with simultaneous pop and event: no drop, new entry last.
    do_reset();
    for (int i = 1; i <= 4; i++) toggle({8'(i), 24'h0});
    tick(1);
    snap_ready = 1'b1;
    toggle({8'h09, 24'h0});
    snap_ready = 1'b0;
    check("fullpop_drop", 32'(drop_cnt), 32'd0);
    pop_expect("fullpop_d2", 8'h02);
    pop_expect("fullpop_d3", 8'h03);
    pop_expect("fullpop_d4", 8'h04);
    pop_expect("fullpop_d9", 8'h09);
    check("fullpop_empty", 32'(snap_valid), 32'd0);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 100; i++) toggle(32'(i));
    check("sat_drop_96", 32'(drop_cnt), 32'h60);
    for (int i = 100; i < 300; i++) toggle(32'(i));
    check("sat_drop_ff", 32'(drop_cnt), 32'hFF);
    check("sat_head", snap_data, 32'h0);

    // Watchdog / motor control.
    do_reset();
    write_cmd(8'hA5);
    check("wd_cmd", 32'(MotCtl), 32'hA5);
    tick(13);
    check("wd_notrip_e14", 32'(wd_trip), 32'd0);
    tick(2);
`ifdef BOT_STATUS_RX_WATCHDOG_EN
    check("wd_trip_e16", 32'(wd_trip), 32'd1);
    check("wd_motctl_forced", 32'(MotCtl), 32'h00);
`else
    check("wd_trip_off", 32'(wd_trip), 32'd0);
    check("wd_motctl_off", 32'(MotCtl), 32'hA5);
`endif
    toggle(32'hCAFE0001);
    check("wd_recover_trip", 32'(wd_trip), 32'd0);
    check("wd_recover_motctl", 32'(MotCtl), 32'hA5);
    tick(16);
    write_cmd(8'h3C);
`ifdef BOT_STATUS_RX_WATCHDOG_EN
    check("wd_trip_again", 32'(wd_trip), 32'd1);
    check("wd_write_in_trip", 32'(MotCtl), 32'h00);
`else
    check("wd_write_off", 32'(MotCtl), 32'h3C);
`endif
    toggle(32'hCAFE0002);
    check("wd_new_cmd", 32'(MotCtl), 32'h3C);
    check("wd_new_trip", 32'(wd_trip), 32'd0);

    // Mid-operation reset flushes queue and counters immediately.
    do_reset();
    for (int i = 1; i <= 5; i++) toggle({8'(i), 24'h0});
    pop_expect("mid_pop1", 8'h01);
    write_cmd(8'h77);
    check("mid_pre_drop", 32'(drop_cnt), 32'd1);
    check("mid_pre_motctl", 32'(MotCtl), 32'h77);
    reset       = 1'b1;
    upd_sysregs = 1'b0;
    #1;
    check("mid_rst_valid", 32'(snap_valid), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_motctl", 32'(MotCtl), 32'd0);
    check("mid_rst_data", snap_data, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(2);
    check("post_rst_idle", 32'(snap_valid), 32'd0);
    toggle(32'hABCDEF01);
    tick(1);
    check("post_rst_data", snap_data, 32'hABCDEF01);
    pop_expect("post_rst_pop", 8'hAB);
    check("post_rst_single", 32'(snap_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bot_status_rx.md
BOT_STATUS_RX -- requirements
Module: bot_status_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, snapshot FIFO entries (power of two, 2..16).
REQ-002 Parameter WD_CYCLES, default 1000000, watchdog timeout in clk cycles (>=2).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 upd_sysregs  input  1  update flag from the world interface; every toggle marks a new consistent status snapshot.
REQ-006 LocX, LocY, BotInfo, Sensors  input  8 each  rojobot status registers, same clock domain.
REQ-007 snap_data  output  32  FIFO head, {LocX,LocY,BotInfo,Sensors} (LocX in [31:24]).
REQ-008 snap_valid  output  1  FIFO non-empty.
REQ-009 snap_ready  input  1  consumer accepts head when high together with snap_valid.
REQ-010 mot_cmd  input  8  motor command {lm_spd[2:0],lm_dir,rm_spd[2:0],rm_dir}.
REQ-011 mot_cmd_wr  input  1  single-cycle load strobe for mot_cmd.
REQ-012 MotCtl  output  8  motor control register returned to the world interface.
REQ-013 drop_cnt  output  8  count of snapshots lost to FIFO full, saturating.
REQ-014 wd_trip  output  1  watchdog tripped, motors forced stopped.

Function
REQ-015 upd_q SHALL register upd_sysregs each cycle; an update event is upd_sysregs != upd_q.
REQ-016 On the clock edge ending an event cycle, the block SHALL push {LocX,LocY,BotInfo,Sensors} as sampled at that edge.
REQ-017 snap_valid SHALL assert the cycle after a push into an empty FIFO (latency 2 cycles from toggle).
REQ-018 A pop SHALL occur on each edge where snap_valid && snap_ready; snap_data SHALL be held stable while snap_valid && !snap_ready.
REQ-019 Event with FIFO full and no pop in the same cycle: snapshot discarded, FIFO contents unchanged, drop_cnt incremented.
REQ-020 Event with FIFO full and a pop in the same cycle: both SHALL occur; no drop.
REQ-021 drop_cnt SHALL saturate at 8'hFF.
REQ-022 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy tracked with an extra pointer bit or a count, never ambiguous.
REQ-023 mot_cmd_wr SHALL load mot_cmd into cmd_reg at that edge; MotCtl SHALL equal cmd_reg unless forced per REQ-026.

Reset
REQ-024 On reset: FIFO empty, snap_valid=0, snap_data=0, drop_cnt=0, upd_q=0, cmd_reg=0, MotCtl=0, wd_trip=0, watchdog counter=0, watchdog state RUN.
REQ-025 Reset asserted mid-operation SHALL flush all queued snapshots immediately; first event after reset release is judged against upd_q=0.

Configuration
REQ-026 Macro BOT_STATUS_RX_WATCHDOG_EN: defined -> two-state watchdog (RUN, TRIP); counter clears on every event, increments otherwise; RUN->TRIP when counter reaches WD_CYCLES-1 without an event; in TRIP wd_trip=1, MotCtl=8'h00, counter frozen; TRIP->RUN on next event, MotCtl=cmd_reg from the following cycle; mot_cmd_wr in TRIP updates cmd_reg but not MotCtl.
REQ-027 Macro undefined -> no watchdog logic, wd_trip tied 0, MotCtl always cmd_reg.

Verification
REQ-028 Toggle upd_sysregs with LocX=8'h12,LocY=8'h34,BotInfo=8'h56,Sensors=8'h78, snap_ready=0 -> snap_valid high 2 cycles after toggle, snap_data=32'h12345678, held.
REQ-029 5 toggles (distinct LocX 1..5), snap_ready=0, FIFO_DEPTH=4 -> drop_cnt=1; draining yields LocX 1,2,3,4 in order.
REQ-030 FIFO full, toggle in same cycle as pop -> no drop, occupancy stays 4, new entry last out.
REQ-031 300 toggles with snap_ready=0 -> drop_cnt=8'hFF, no wrap.
REQ-032 Watchdog defined, WD_CYCLES=16, mot_cmd=8'hA5 written, no toggles -> wd_trip=1 and MotCtl=8'h00 after 16 cycles; one toggle -> wd_trip=0, MotCtl=8'hA5.
REQ-033 Reset pulsed with 3 entries queued -> snap_valid=0, drop_cnt=0, MotCtl=0 immediately; next toggle produces a single entry.
